// File: rtl/id_gen.sv
// Identifier generator: after a start pulse it streams a run of letters, then a run of
// digits, then one separator character over a valid/ready handshake, and pulses done.
module id_gen #(
    parameter int          LEN_W    = 5,
    parameter logic [7:0]  SEP_CHAR = 8'h20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] letter_cnt,
    input  logic [LEN_W-1:0] digit_cnt,
    input  logic [4:0]       letter_base,
    input  logic             upper,
    output logic [7:0]       char,
    output logic             char_valid,
    input  logic             char_ready,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LETTER = 3'd1,
        DIGIT  = 3'd2,
        SEP    = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] letters_left_q, letters_left_d;
    logic [LEN_W-1:0] digits_left_q, digits_left_d;
    logic [4:0]       letter_idx_q, letter_idx_d;
    logic [3:0]       digit_idx_q, digit_idx_d;
    logic             upper_q, upper_d;
    logic [7:0]       char_q, char_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             accept;
    logic [4:0]       base_mod;

    assign accept   = valid_q && char_ready;
    assign base_mod = (letter_base >= 5'd26) ? (letter_base - 5'd26) : letter_base;

    always_comb begin
        state_d        = state_q;
        letters_left_d = letters_left_q;
        digits_left_d  = digits_left_q;
        letter_idx_d   = letter_idx_q;
        digit_idx_d    = digit_idx_q;
        upper_d        = upper_q;

        case (state_q)
            IDLE: begin
                if (start && (letter_cnt != '0)) begin
                    state_d        = LETTER;
                    letters_left_d = letter_cnt;
                    digits_left_d  = digit_cnt;
                    upper_d        = upper;
                    letter_idx_d   = base_mod;
                    digit_idx_d    = 4'd0;
                end
            end
            LETTER: begin
                if (accept) begin
                    letters_left_d = letters_left_q - 1'b1;
                    letter_idx_d   = (letter_idx_q == 5'd25) ? 5'd0 : letter_idx_q + 5'd1;
                    if (letters_left_q == LEN_W'(1)) begin
                        state_d = (digits_left_q != '0) ? DIGIT : SEP;
                    end
                end
            end
            DIGIT: begin
                if (accept) begin
                    digits_left_d = digits_left_q - 1'b1;
                    digit_idx_d   = (digit_idx_q == 4'd9) ? 4'd0 : digit_idx_q + 4'd1;
                    if (digits_left_q == LEN_W'(1)) begin
                        state_d = SEP;
                    end
                end
            end
            SEP: begin
                if (accept) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they can be registered without any
    // combinational path from char_ready; a stall leaves every _d equal to its _q.
    always_comb begin
        char_d  = 8'h00;
        valid_d = 1'b0;
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
        case (state_d)
            LETTER: begin
                char_d  = (upper_d ? 8'd65 : 8'd97) + {3'b000, letter_idx_d};
                valid_d = 1'b1;
            end
            DIGIT: begin
                char_d  = 8'd48 + {4'b0000, digit_idx_d};
                valid_d = 1'b1;
            end
            SEP: begin
                char_d  = SEP_CHAR;
                valid_d = 1'b1;
            end
            default: begin
                char_d  = 8'h00;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            letters_left_q <= '0;
            digits_left_q  <= '0;
            letter_idx_q   <= 5'd0;
            digit_idx_q    <= 4'd0;
            upper_q        <= 1'b0;
            char_q         <= 8'h00;
            valid_q        <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            letters_left_q <= letters_left_d;
            digits_left_q  <= digits_left_d;
            letter_idx_q   <= letter_idx_d;
            digit_idx_q    <= digit_idx_d;
            upper_q        <= upper_d;
            char_q         <= char_d;
            valid_q        <= valid_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign char       = char_q;
    assign char_valid = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
